udp_stream_reducer: RTL

- Parametrised successor to the fixed 63-beat UDP reduce parser: consumes framed packets on a wide valid/ready stream and emits one WORD_W reduction result per packet.
- Packet = 1 header beat (opcode, payload word count), then variable-length payload beats terminated by a_last_i.
- Supports SUM/MAX/MIN/XOR over unsigned words, with error reporting.
- Sits between the UDP payload extractor and the result collector.

---
 rtl/udp_reducer_pkg.sv | 37 +++
 rtl/udp_lane_reduce.sv | 82 ++++++++
 rtl/udp_stream_reducer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/udp_reducer_pkg.sv
// Shared types and constants for the UDP stream reducer.
//   op_e      : supported reduction opcodes (header byte 0)
//   state_e   : packet FSM states
//   OP_LSB / CNT_LSB : header field positions
//   ERR_OP / ERR_LEN : bit positions in the error vector
package udp_reducer_pkg;

    typedef enum logic [7:0] {
        OP_SUM = 8'h01,
        OP_MAX = 8'h02,
        OP_MIN = 8'h03,
        OP_XOR = 8'h04
    } op_e;

    typedef enum logic [1:0] {
        S_HDR,
        S_PAYLOAD,
        S_OUT
    } state_e;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned OP_LSB  = 0;
    localparam int unsigned CNT_LSB = 8;

    localparam int unsigned ERR_OP  = 0;
    localparam int unsigned ERR_LEN = 1;

    function automatic logic op_known(input logic [OP_W-1:0] op);
        return (op == OP_SUM) || (op == OP_MAX) || (op == OP_MIN) || (op == OP_XOR);
    endfunction

    // MIN starts from all-ones; every other op starts from zero.
    function automatic logic op_is_min(input logic [OP_W-1:0] op);
        return op == OP_MIN;
    endfunction

endpackage

// File: rtl/udp_lane_reduce.sv
// Combinational reduction of one input beat into the running accumulator.
//   op_i   : opcode selecting SUM/MAX/MIN/XOR (anything else passes acc_i through)
//   acc_i  : current accumulator
//   data_i : input beat, LANES words of WORD_W bits
//   mask_i : per-lane enable; disabled lanes do not affect the result
//   acc_o  : next accumulator value
//   sat_o  : SUM saturated this beat (only with UDP_REDUCER_SAT_EN)
// Build option: UDP_REDUCER_SAT_EN makes SUM saturate instead of wrapping.
module udp_lane_reduce
    import udp_reducer_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANES  = DATA_W / WORD_W
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [WORD_W-1:0] acc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LANES-1:0]  mask_i,
`ifdef UDP_REDUCER_SAT_EN
    output logic              sat_o,
`endif
    output logic [WORD_W-1:0] acc_o
);

`ifdef UDP_REDUCER_SAT_EN
    // Wide enough that LANES+1 words can never overflow.
    localparam int unsigned SUM_W = WORD_W + $clog2(LANES + 1);
`else
    localparam int unsigned SUM_W = WORD_W;
`endif

    logic [SUM_W-1:0]  sum;
    logic [WORD_W-1:0] word;

    always_comb begin
        acc_o = acc_i;
        sum   = SUM_W'(acc_i);
        word  = '0;
`ifdef UDP_REDUCER_SAT_EN
        sat_o = 1'b0;
`endif
        case (op_i)
            OP_SUM: begin
                for (int i = 0; i < LANES; i++) begin
                    word = data_i[i*WORD_W +: WORD_W];
                    if (mask_i[i]) sum = sum + SUM_W'(word);
                end
`ifdef UDP_REDUCER_SAT_EN
                if (sum[SUM_W-1:WORD_W] != '0) begin
                    acc_o = '1;
                    sat_o = 1'b1;
                end else begin
                    acc_o = sum[WORD_W-1:0];
                end
`else
                acc_o = sum;
`endif
            end
            OP_MAX: begin
                for (int i = 0; i < LANES; i++) begin
                    word = data_i[i*WORD_W +: WORD_W];
                    if (mask_i[i] && (word > acc_o)) acc_o = word;
                end
            end
            OP_MIN: begin
                for (int i = 0; i < LANES; i++) begin
                    word = data_i[i*WORD_W +: WORD_W];
                    if (mask_i[i] && (word < acc_o)) acc_o = word;
                end
            end
            OP_XOR: begin
                for (int i = 0; i < LANES; i++) begin
                    word = data_i[i*WORD_W +: WORD_W];
                    if (mask_i[i]) acc_o = acc_o ^ word;
                end
            end
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/udp_stream_reducer.sv
// Consumes framed packets (1 header beat + payload beats ending on a_last_i) and emits one
// WORD_W reduction result per packet with error flags.
//   clock, reset        : rising-edge clock, synchronous active-low reset
//   a_data_i/a_valid_i/a_last_i/a_ready_o : input beat stream
//   b_data_o/b_op_o/b_err_o/b_valid_o/b_ready_i : result stream
//     b_err_o[0] unknown opcode, b_err_o[1] length mismatch
// Build option: UDP_REDUCER_SAT_EN makes SUM saturate at all-ones.
module udp_stream_reducer
    import udp_reducer_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_BEATS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_valid_i,
    input  logic              a_last_i,
    output logic              a_ready_o,
    output logic [WORD_W-1:0] b_data_o,
    output logic [OP_W-1:0]   b_op_o,
    output logic [1:0]        b_err_o,
    output logic              b_valid_o,
    input  logic              b_ready_i
);

    localparam int unsigned LANES  = DATA_W / WORD_W;
    localparam int unsigned CW1    = CNT_W + 1;
    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 2);
    // Beat counter sticks one past the limit; that is enough to flag overlength.
    localparam logic [BEAT_W-1:0] BEAT_SAT = BEAT_W'(MAX_BEATS + 1);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              unk_q, unk_d;
    logic [WORD_W-1:0] b_data_q, b_data_d;
    logic [OP_W-1:0]   b_op_q, b_op_d;
    logic [1:0]        b_err_q, b_err_d;
`ifdef UDP_REDUCER_SAT_EN
    logic              sat_q, sat_d;
    logic              red_sat;
`endif

    logic [LANES-1:0]  lane_mask;
    logic [WORD_W-1:0] red_acc;
    logic [CNT_W-1:0]  rem_next;
    logic [BEAT_W-1:0] beats_inc;
    logic [CW1-1:0]    ceil_beats;
    logic              len_err;
    logic [OP_W-1:0]   hdr_op;
    logic [CNT_W-1:0]  hdr_n;
    logic              hdr_unk;

    udp_lane_reduce #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .LANES  (LANES)
    ) u_lane_reduce (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .data_i (a_data_i),
        .mask_i (lane_mask),
`ifdef UDP_REDUCER_SAT_EN
        .sat_o  (red_sat),
`endif
        .acc_o  (red_acc)
    );

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = CW1'(i) < {1'b0, rem_q};
        end
        rem_next   = (rem_q > CNT_W'(LANES)) ? rem_q - CNT_W'(LANES) : '0;
        beats_inc  = (beats_q == BEAT_SAT) ? beats_q : beats_q + BEAT_W'(1);
        ceil_beats = ({1'b0, n_q} + CW1'(LANES - 1)) / CW1'(LANES);
        len_err    = (rem_next != '0) || (CW1'(beats_inc) != ceil_beats) ||
                     (beats_inc > BEAT_W'(MAX_BEATS));
        hdr_op     = a_data_i[OP_LSB +: OP_W];
        hdr_n      = a_data_i[CNT_LSB +: CNT_W];
        hdr_unk    = !op_known(hdr_op);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        n_d      = n_q;
        rem_d    = rem_q;
        beats_d  = beats_q;
        acc_d    = acc_q;
        unk_d    = unk_q;
        b_data_d = b_data_q;
        b_op_d   = b_op_q;
        b_err_d  = b_err_q;
`ifdef UDP_REDUCER_SAT_EN
        sat_d    = sat_q;
`endif
        unique case (state_q)
            S_HDR: begin
                if (a_valid_i) begin
                    op_d    = hdr_op;
                    n_d     = hdr_n;
                    rem_d   = hdr_n;
                    beats_d = '0;
                    acc_d   = op_is_min(hdr_op) ? '1 : '0;
                    unk_d   = hdr_unk;
`ifdef UDP_REDUCER_SAT_EN
                    sat_d   = 1'b0;
`endif
                    if (a_last_i) begin
                        state_d          = S_OUT;
                        b_data_d         = hdr_unk ? '0 : acc_d;
                        b_op_d           = hdr_op;
                        b_err_d[ERR_OP]  = hdr_unk;
                        b_err_d[ERR_LEN] = hdr_n != '0;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (a_valid_i) begin
                    beats_d = beats_inc;
                    rem_d   = rem_next;
                    // Beats past the limit are drained without touching the result.
                    if (beats_q < BEAT_W'(MAX_BEATS)) begin
`ifdef UDP_REDUCER_SAT_EN
                        sat_d = sat_q | red_sat;
                        acc_d = (sat_q && (op_q == OP_SUM)) ? '1 : red_acc;
`else
                        acc_d = red_acc;
`endif
                    end
                    if (a_last_i) begin
                        state_d          = S_OUT;
                        b_data_d         = unk_q ? '0 : acc_d;
                        b_op_d           = op_q;
                        b_err_d[ERR_OP]  = unk_q;
                        b_err_d[ERR_LEN] = len_err;
                    end
                end
            end
            S_OUT: begin
                if (b_ready_i) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_HDR;
            op_q     <= '0;
            n_q      <= '0;
            rem_q    <= '0;
            beats_q  <= '0;
            acc_q    <= '0;
            unk_q    <= 1'b0;
            b_data_q <= '0;
            b_op_q   <= '0;
            b_err_q  <= '0;
`ifdef UDP_REDUCER_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            n_q      <= n_d;
            rem_q    <= rem_d;
            beats_q  <= beats_d;
            acc_q    <= acc_d;
            unk_q    <= unk_d;
            b_data_q <= b_data_d;
            b_op_q   <= b_op_d;
            b_err_q  <= b_err_d;
`ifdef UDP_REDUCER_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign a_ready_o = state_q != S_OUT;
    assign b_valid_o = state_q == S_OUT;
    assign b_data_o  = b_data_q;
    assign b_op_o    = b_op_q;
    assign b_err_o   = b_err_q;

endmodule
